// File: rtl/z3_master_cycle.sv
// Zorro III bus-master cycle engine for the NCR 53C710 DMA path.
// Converts each 710 master access into a Zorro III full cycle once the
// bus is held. It then waits for a synchronized DTACK or BERR and
// terminates the 710 with STERM_n or NCR_BERR_n.
// Buffer direction is handled elsewhere; this block only drives the
// buffer enables and the Zorro strobes.
module z3_master_cycle #(
   parameter int TIMEOUT_CYCLES = 64,  // WAIT cycles without DTACK before bus error (4..255)
   parameter int ADDR_SETUP     = 1    // address phase cycles before FCS_n asserts (1..3)
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       BMASTER,
   input  logic       NCR_AS_n,
   input  logic       NCR_READ,
   input  logic [1:0] NCR_SIZ,
   input  logic [1:0] NCR_A,
   input  logic       Z_DTACK_n,
   input  logic       Z_BERR_n,
   output logic       FCS_n,
   output logic [3:0] DS_n,
   output logic       DOE,
   output logic       Z_READ,
   output logic       ABOE_n,
   output logic       DBOE_n,
   output logic       STERM_n,
   output logic       NCR_BERR_n,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_STROBE,
      S_WAIT,
      S_TERM,
      S_RECOVER
   } state_t;

   localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0] SETUP_LAST = 2'(ADDR_SETUP - 1);

   state_t     state_q;
   logic       read_q;
   logic [1:0] siz_q;
   logic [1:0] a_q;
   logic [1:0] setup_cnt_q;
   logic [7:0] tmo_cnt_q;

   logic       dtack_s1_q;
   logic       dtack_s2_q;
   logic       berr_s1_q;
   logic       berr_s2_q;

   logic       fcs_n_q;
   logic [3:0] ds_n_q;
   logic       doe_q;
   logic       z_read_q;
   logic       aboe_n_q;
   logic       dboe_n_q;
   logic       sterm_n_q;
   logic       ncr_berr_n_q;
   logic       busy_q;

   // Byte-lane decode from the latched size/offset (68030 rule):
   // offsets A .. min(A+N-1, 3) are enabled, with SIZ=00 meaning 4 bytes.
   logic [2:0] size_bytes;
   logic [2:0] last_off;
   logic [3:0] ds_lane_n;

   assign size_bytes = (siz_q == 2'b00) ? 3'd4 : {1'b0, siz_q};
   assign last_off   = {1'b0, a_q} + size_bytes - 3'd1;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [2:0] OFF = 3'(gi);
         // DS_n[3] carries byte offset 0 (D31:24)
         assign ds_lane_n[3 - gi] = !(({1'b0, a_q} <= OFF) && (OFF <= last_off));
      end
   endgenerate

   // Two-flop synchronizers for the asynchronous Zorro responses.
   always_ff @(posedge CLK) begin
      if (RST) begin
         dtack_s1_q <= 1'b1;
         dtack_s2_q <= 1'b1;
         berr_s1_q  <= 1'b1;
         berr_s2_q  <= 1'b1;
      end else begin
         dtack_s1_q <= Z_DTACK_n;
         dtack_s2_q <= dtack_s1_q;
         berr_s1_q  <= Z_BERR_n;
         berr_s2_q  <= berr_s1_q;
      end
   end

   // Cycle FSM with registered bus and 710 outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= S_IDLE;
         read_q       <= 1'b1;
         siz_q        <= 2'b00;
         a_q          <= 2'b00;
         setup_cnt_q  <= 2'd0;
         tmo_cnt_q    <= 8'd0;
         fcs_n_q      <= 1'b1;
         ds_n_q       <= 4'hF;
         doe_q        <= 1'b0;
         z_read_q     <= 1'b1;
         aboe_n_q     <= 1'b1;
         dboe_n_q     <= 1'b1;
         sterm_n_q    <= 1'b1;
         ncr_berr_n_q <= 1'b1;
         busy_q       <= 1'b0;
      end else begin
         // Terminations are single-cycle pulses; default them off.
         sterm_n_q    <= 1'b1;
         ncr_berr_n_q <= 1'b1;

         case (state_q)
            S_IDLE: begin
               // BMASTER only gates the start of a cycle.
               if (!NCR_AS_n && BMASTER) begin
                  state_q     <= S_ADDR;
                  read_q      <= NCR_READ;
                  siz_q       <= NCR_SIZ;
                  a_q         <= NCR_A;
                  setup_cnt_q <= 2'd0;
                  aboe_n_q    <= 1'b0;
                  z_read_q    <= NCR_READ;
                  busy_q      <= 1'b1;
               end
            end

            S_ADDR: begin
               if (NCR_AS_n) begin
                  // 710 withdrew the access: release the bus silently.
                  state_q  <= S_RECOVER;
                  fcs_n_q  <= 1'b1;
                  ds_n_q   <= 4'hF;
                  doe_q    <= 1'b0;
                  dboe_n_q <= 1'b1;
                  aboe_n_q <= 1'b1;
                  z_read_q <= 1'b1;
               end else if (setup_cnt_q == SETUP_LAST) begin
                  state_q <= S_STROBE;
                  fcs_n_q <= 1'b0;
               end else begin
                  setup_cnt_q <= setup_cnt_q + 2'd1;
               end
            end

            S_STROBE: begin
               if (NCR_AS_n) begin
                  state_q  <= S_RECOVER;
                  fcs_n_q  <= 1'b1;
                  ds_n_q   <= 4'hF;
                  doe_q    <= 1'b0;
                  dboe_n_q <= 1'b1;
                  aboe_n_q <= 1'b1;
                  z_read_q <= 1'b1;
               end else begin
                  state_q   <= S_WAIT;
                  ds_n_q    <= ds_lane_n;
                  dboe_n_q  <= 1'b0;
                  doe_q     <= !read_q;
                  tmo_cnt_q <= 8'd0;
               end
            end

            S_WAIT: begin
               // Priority: abort, then BERR, then DTACK, then timeout.
               if (!NCR_AS_n && berr_s2_q && !dtack_s2_q) begin
                  state_q   <= S_TERM;
                  sterm_n_q <= 1'b0;
               end else if (NCR_AS_n || !berr_s2_q || (tmo_cnt_q == TMO_LAST)) begin
                  state_q      <= S_RECOVER;
                  ncr_berr_n_q <= NCR_AS_n;  // an abort gets no bus error
                  fcs_n_q      <= 1'b1;
                  ds_n_q       <= 4'hF;
                  doe_q        <= 1'b0;
                  dboe_n_q     <= 1'b1;
                  aboe_n_q     <= 1'b1;
                  z_read_q     <= 1'b1;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 8'd1;
               end
            end

            S_TERM: begin
               // Strobes were held through TERM so the 710 could sample data.
               state_q  <= S_RECOVER;
               fcs_n_q  <= 1'b1;
               ds_n_q   <= 4'hF;
               doe_q    <= 1'b0;
               dboe_n_q <= 1'b1;
               aboe_n_q <= 1'b1;
               z_read_q <= 1'b1;
            end

            S_RECOVER: begin
               // Wait for the 710 and the target to let go before idling.
               if (NCR_AS_n && dtack_s2_q) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end

            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign FCS_n      = fcs_n_q;
   assign DS_n       = ds_n_q;
   assign DOE        = doe_q;
   assign Z_READ     = z_read_q;
   assign ABOE_n     = aboe_n_q;
   assign DBOE_n     = dboe_n_q;
   assign STERM_n    = sterm_n_q;
   assign NCR_BERR_n = ncr_berr_n_q;
   assign busy       = busy_q;

endmodule
